// File: rtl/microwave_pkg.sv
// Shared microwave definitions: controller state encoding, BCD limits and the M:SS time word.
package microwave_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned BCD_MAX      = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;

  localparam mmss_t ZERO_TIME = '0;

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad/control inputs and display/magnetron outputs of the countdown controller.
interface timer_ctrl_if;
  import microwave_pkg::*;

  logic               tick_1hz;
  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               start;
  logic               stop;
  logic               clear;
  logic               door_closed;
  logic [DIGIT_W-1:0] min;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic               mag_on;
  logic               done;

  modport master (
    output tick_1hz, key_valid, key_digit, start, stop, clear, door_closed,
    input  min, sec_tens, sec_ones, mag_on, done
  );

  modport slave (
    input  tick_1hz, key_valid, key_digit, start, stop, clear, door_closed,
    output min, sec_tens, sec_ones, mag_on, done
  );
endinterface

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD M:SS time; caller guarantees input is not 0:00.
module bcd_mmss_dec
  import microwave_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  is_zero
);

  always_comb begin
    nxt = cur;
    if (cur.sec_ones != '0) begin
      nxt.sec_ones = cur.sec_ones - DIGIT_W'(1);
    end else begin
      nxt.sec_ones = DIGIT_W'(BCD_MAX);
      if (cur.sec_tens != '0) begin
        nxt.sec_tens = cur.sec_tens - DIGIT_W'(1);
      end else begin
        nxt.sec_tens = DIGIT_W'(SEC_TENS_MAX);
        nxt.min      = cur.min - DIGIT_W'(1);
      end
    end
  end

  assign is_zero = (nxt == ZERO_TIME);

endmodule

// File: rtl/timer_ctrl.sv
// Microwave countdown controller: keypad entry, start/stop/clear, door interlock, 1 Hz countdown.
module timer_ctrl #(
  parameter int unsigned MAX_MIN      = 9,
  parameter int unsigned SEC_TENS_MAX = microwave_pkg::SEC_TENS_MAX
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);
  import microwave_pkg::*;

  state_t state;
  mmss_t  tm;
  mmss_t  tm_dec;
  logic   dec_zero;
  logic   mag_on_q;
  logic   done_q;
  logic   key_ok;
  logic   start_ok;

  bcd_mmss_dec u_dec (
    .cur     (tm),
    .nxt     (tm_dec),
    .is_zero (dec_zero)
  );

  // A key is taken only if every shifted digit stays legal in its new position.
  assign key_ok = (bus.key_digit <= DIGIT_W'(BCD_MAX))
               && (tm.sec_ones <= DIGIT_W'(SEC_TENS_MAX))
               && (tm.sec_tens <= DIGIT_W'(MAX_MIN));

  assign start_ok = bus.door_closed
                 && ((state == PAUSE) || ((state == SET) && (tm != ZERO_TIME)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SET;
      tm       <= ZERO_TIME;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        state    <= SET;
        tm       <= ZERO_TIME;
        mag_on_q <= 1'b0;
      end else if (!bus.door_closed && (state == RUN)) begin
        state    <= PAUSE;
        mag_on_q <= 1'b0;
      end else if (bus.stop && (state != SET)) begin
        mag_on_q <= 1'b0;
        if (state == RUN) begin
          state <= PAUSE;
        end else begin
          state <= SET;
          tm    <= ZERO_TIME;
        end
      end else if (bus.start && start_ok) begin
        state    <= RUN;
        mag_on_q <= 1'b1;
      end else if (bus.tick_1hz && (state == RUN)) begin
        tm <= tm_dec;
        if (dec_zero) begin
          state    <= SET;
          mag_on_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end else if (bus.key_valid && (state == SET) && key_ok) begin
        tm <= '{min: tm.sec_tens, sec_tens: tm.sec_ones, sec_ones: bus.key_digit};
      end
    end
  end

  assign bus.min      = tm.min;
  assign bus.sec_tens = tm.sec_tens;
  assign bus.sec_ones = tm.sec_ones;
  assign bus.mag_on   = mag_on_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and randomized checks of timer_ctrl against a seconds-based reference model.
module tb_timer_ctrl;

  logic clk;
  logic reset;
  logic door;
  int   n_checks;
  int   n_errors;

  timer_ctrl_if bus ();

  timer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: mode 0=idle/entry, 1=counting, 2=paused; time kept as three digits
  int  m_mode;
  int  m_d[3];
  bit  m_done;

  function automatic int m_secs();
    return m_d[0] * 60 + m_d[1] * 10 + m_d[2];
  endfunction

  function automatic void m_load_secs(input int s);
    m_d[0] = s / 60;
    m_d[1] = (s % 60) / 10;
    m_d[2] = s % 10;
  endfunction

  function automatic void m_step(input bit tk, input bit kv, input int kd,
                                 input bit st, input bit sp, input bit cl, input bit dc);
    m_done = 0;
    if (cl) begin
      m_mode = 0; m_load_secs(0);
    end else if (!dc && m_mode == 1) begin
      m_mode = 2;
    end else if (sp && m_mode != 0) begin
      if (m_mode == 1) m_mode = 2;
      else begin m_mode = 0; m_load_secs(0); end
    end else if (st && dc && (m_mode == 2 || (m_mode == 0 && m_secs() != 0))) begin
      m_mode = 1;
    end else if (tk && m_mode == 1) begin
      m_load_secs(m_secs() - 1);
      if (m_secs() == 0) begin m_mode = 0; m_done = 1; end
    end else if (kv && m_mode == 0 && kd <= 9 && m_d[2] <= 5 && m_d[1] <= 9) begin
      m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = kd;
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_time();
    return {4'd0, bus.min, bus.sec_tens, bus.sec_ones};
  endfunction

  function automatic logic [15:0] model_time();
    return {4'd0, 4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2])};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".time"}, dut_time(), model_time());
    check({tag, ".mag_on"}, 16'(bus.mag_on), 16'(m_mode == 1));
    check({tag, ".done"}, 16'(bus.done), 16'(m_done));
  endtask

  task automatic idle_inputs();
    bus.tick_1hz  = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic cyc(input string tag, input bit tk, input bit kv, input int kd,
                     input bit st, input bit sp, input bit cl);
    bus.tick_1hz    = tk;
    bus.key_valid   = kv;
    bus.key_digit   = 4'(kd);
    bus.start       = st;
    bus.stop        = sp;
    bus.clear       = cl;
    bus.door_closed = door;
    @(posedge clk);
    m_step(tk, kv, kd, st, sp, cl, door);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  task automatic key(input int d);   cyc("key", 0, 1, d, 0, 0, 0); endtask
  task automatic tick();             cyc("tick", 1, 0, 0, 0, 0, 0); endtask
  task automatic press_start();      cyc("start", 0, 0, 0, 1, 0, 0); endtask
  task automatic press_stop();       cyc("stop", 0, 0, 0, 0, 1, 0); endtask
  task automatic press_clear();      cyc("clear", 0, 0, 0, 0, 0, 1); endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    m_mode = 0; m_done = 0; m_load_secs(0);
    #1;
    reset = 1'b0;
    check_all("reset");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    door     = 1'b1;
    bus.door_closed = 1'b1;
    reset    = 1'b1;
    idle_inputs();
    m_mode = 0; m_done = 0; m_load_secs(0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset_time", dut_time(), 16'h0000);

    // entry rules
    key(1); key(3); key(0);
    check("entry_130", dut_time(), 16'h0130);
    key(7);
    check("entry_307", dut_time(), 16'h0307);
    key(9);
    check("entry_reject", dut_time(), 16'h0307);
    press_clear();
    key(12);
    check("entry_gt9", dut_time(), 16'h0000);

    // countdown from 1:00, consecutive ticks, completion
    key(1); key(0); key(0);
    press_start();
    tick();
    check("cnt_059", dut_time(), 16'h0059);
    check("cnt_mag", 16'(bus.mag_on), 16'd1);
    repeat (49) tick();
    check("cnt_010", dut_time(), 16'h0010);
    tick();
    check("cnt_009", dut_time(), 16'h0009);
    repeat (8) tick();
    check("cnt_001", dut_time(), 16'h0001);
    tick();
    check("done_pulse", 16'(bus.done), 16'd1);
    check("done_mag", 16'(bus.mag_on), 16'd0);
    cyc("idle", 0, 0, 0, 0, 0, 0);
    check("done_one", 16'(bus.done), 16'd0);

    // door interlock
    key(4); key(5); press_start();
    door = 1'b0;
    cyc("door_open", 0, 0, 0, 0, 0, 0);
    check("door_mag", 16'(bus.mag_on), 16'd0);
    press_start();
    check("door_start", 16'(bus.mag_on), 16'd0);
    door = 1'b1;
    press_start();
    check("door_resume", dut_time(), 16'h0045);
    check("door_resume_mag", 16'(bus.mag_on), 16'd1);

    // stop / clear
    press_clear();
    key(2); key(1); key(0); press_start();
    press_stop();
    check("stop_pause", dut_time(), 16'h0210);
    press_stop();
    check("stop_set", dut_time(), 16'h0000);
    press_start();
    check("start_zero", 16'(bus.mag_on), 16'd0);

    // reset mid-run
    key(5); press_start();
    do_reset();
    check("rst_run_done", 16'(bus.done), 16'd0);

    // collisions
    key(5); press_start();
    cyc("tick_stop", 1, 0, 0, 0, 1, 0);
    check("tick_stop_time", dut_time(), 16'h0005);
    press_clear();
    key(1); press_start();
    door = 1'b0;
    cyc("tick_door", 1, 0, 0, 0, 0, 0);
    check("tick_door_time", dut_time(), 16'h0001);
    check("tick_door_done", 16'(bus.done), 16'd0);
    door = 1'b1;
    press_clear();
    key(2);
    cyc("start_key", 0, 1, 3, 1, 0, 0);
    check("start_key_time", dut_time(), 16'h0002);
    check("start_key_mag", 16'(bus.mag_on), 16'd1);

    // randomized single-event traffic with a wandering door
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      door = ($urandom_range(0, 9) != 0);
      if (r < 30)      cyc("rnd_tick", 1, 0, 0, 0, 0, 0);
      else if (r < 62) cyc("rnd_key", 0, 1, int'($urandom_range(0, 11)), 0, 0, 0);
      else if (r < 75) cyc("rnd_start", 0, 0, 0, 1, 0, 0);
      else if (r < 81) cyc("rnd_stop", 0, 0, 0, 0, 1, 0);
      else if (r < 83) cyc("rnd_clear", 0, 0, 0, 0, 0, 1);
      else             cyc("rnd_idle", 0, 0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
